// File: rtl/uart_rx_pkg.sv
// Shared UART RX definitions: prescale constants and the majority vote.
// The sampler, parity and stop checkers all vote with majority3.
package uart_rx_pkg;

  localparam int PRESCALE_WIDTH_DEF = 6;
  localparam int PRESCALE_MIN       = 6;
  localparam int PRESCALE_8         = 8;
  localparam int PRESCALE_16        = 16;
  localparam int PRESCALE_32        = 32;

  function automatic logic majority3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous RX line.
// Resets to 1 so the line reads as idle.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_data_sampler.sv
// UART RX oversampling front end: edge counter, three-point mid-bit
// sampling with majority vote, valid and bit_done strobes.
module uart_rx_data_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      sampler_enable,
  output logic                      sampled_bit,
  output logic                      valid_sampled_bit,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic                      bit_done
);

  localparam logic [PRESCALE_WIDTH-1:0] P_MIN =
    PRESCALE_WIDTH'(PRESCALE_MIN);
  localparam logic [PRESCALE_WIDTH-1:0] ONE =
    PRESCALE_WIDTH'(1);

  logic                      w_rx_s;
  logic                      w_en;
  logic [PRESCALE_WIDTH-1:0] w_half;
  logic [PRESCALE_WIDTH-1:0] w_last;
  logic                      w_wrap;
  logic                      w_at_s0;
  logic                      w_at_s1;
  logic                      w_at_vote;

  logic [PRESCALE_WIDTH-1:0] r_edge_cnt;
  logic                      r_s0;
  logic                      r_s1;
  logic                      r_bit;
  logic                      r_valid;
  logic                      r_done;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK     (CLK),
    .RST     (RST),
    .i_async (RX_IN),
    .o_sync  (w_rx_s)
  );

  // Illegal (too small) prescale behaves exactly like idle.
  assign w_en      = sampler_enable & (Prescale >= P_MIN);
  assign w_half    = Prescale >> 1;
  assign w_last    = Prescale - ONE;
  // >= keeps the counter bounded if Prescale shrinks mid-bit.
  assign w_wrap    = r_edge_cnt >= w_last;
  assign w_at_s0   = r_edge_cnt == (w_half - ONE);
  assign w_at_s1   = r_edge_cnt == w_half;
  assign w_at_vote = r_edge_cnt == (w_half + ONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_bit      <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else if (!w_en) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_edge_cnt <= w_wrap ? '0 : r_edge_cnt + ONE;
      r_done     <= w_wrap;
      r_valid    <= w_at_vote;
      if (w_at_s0) begin
        r_s0 <= w_rx_s;
      end
      if (w_at_s1) begin
        r_s1 <= w_rx_s;
      end
      if (w_at_vote) begin
        r_bit <= majority3(r_s0, r_s1, w_rx_s);
      end
    end
  end

  assign sampled_bit       = r_bit;
  assign valid_sampled_bit = r_valid;
  assign edge_cnt          = r_edge_cnt;
  assign bit_done          = r_done;

endmodule

// File: tb/tb_uart_rx_data_sampler.sv
// Directed bench for uart_rx_data_sampler.
// Inputs change 1ns after posedge; outputs are checked at the same point.
module tb_uart_rx_data_sampler;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       sampler_enable;
  logic       sampled_bit;
  logic       valid_sampled_bit;
  logic [5:0] edge_cnt;
  logic       bit_done;

  int n_cmp;
  int n_err;

  uart_rx_data_sampler dut (
    .CLK               (CLK),
    .RST               (RST),
    .RX_IN             (RX_IN),
    .Prescale          (Prescale),
    .sampler_enable    (sampler_enable),
    .sampled_bit       (sampled_bit),
    .valid_sampled_bit (valid_sampled_bit),
    .edge_cnt          (edge_cnt),
    .bit_done          (bit_done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Assumes edge_cnt==0 and enable high at entry; RX_IN held constant.
  task automatic run_window(
    input string tag,
    input int    p,
    input int    n,
    input logic  bit_exp
  );
    int c;
    for (int i = 0; i < n; i++) begin
      step();
      c = (i + 1) % p;
      chk({tag, "_cnt"}, edge_cnt, c);
      chk({tag, "_vld"}, valid_sampled_bit, c == p / 2 + 2);
      chk({tag, "_done"}, bit_done, c == 0);
      if (c == p / 2 + 2)
        chk({tag, "_bit"}, sampled_bit, bit_exp);
    end
  endtask

  logic [9:0] frame;
  int         c;
  int         n_vld;
  int         n_done;
  int         peak;
  int         b;

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    RST            = 1'b1;
    RX_IN          = 1'b1;
    Prescale       = 6'd8;
    sampler_enable = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("rst_cnt", edge_cnt, 0);
    chk("rst_vld", valid_sampled_bit, 0);
    chk("rst_done", bit_done, 0);
    chk("rst_bit", sampled_bit, 0);

    // P=8, low bit, two bit periods
    RX_IN = 1'b0;
    step();
    step();
    chk("p8_idle_cnt", edge_cnt, 0);
    sampler_enable = 1'b1;
    run_window("p8", 8, 16, 1'b0);

    // P=16, one-cycle glitch seen by rx_s at edge 8
    sampler_enable = 1'b0;
    Prescale       = 6'd16;
    RX_IN          = 1'b1;
    repeat (3) step();
    sampler_enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      RX_IN = (i == 6) ? 1'b0 : 1'b1;
      step();
      c = (i + 1) % 16;
      chk("p16_vld", valid_sampled_bit, c == 10);
      if (c == 10)
        chk("p16_bit", sampled_bit, 1);
    end
    chk("p16_wrap_cnt", edge_cnt, 0);
    chk("p16_wrap_done", bit_done, 1);

    // P=32, ten-bit frame
    frame          = 10'b1010011010;
    sampler_enable = 1'b0;
    Prescale       = 6'd32;
    RX_IN          = 1'b1;
    repeat (3) step();
    sampler_enable = 1'b1;
    n_vld  = 0;
    n_done = 0;
    peak   = 0;
    for (int i = 0; i < 320; i++) begin
      b     = (i + 2) / 32;
      RX_IN = (b < 10) ? frame[b] : 1'b1;
      step();
      c = (i + 1) % 32;
      chk("p32_cnt", edge_cnt, c);
      if (int'(edge_cnt) > peak)
        peak = int'(edge_cnt);
      if (valid_sampled_bit) begin
        n_vld++;
        chk("p32_vld_pos", c, 18);
        chk("p32_bit", sampled_bit, frame[(i + 1) / 32]);
      end
      if (bit_done) begin
        n_done++;
        chk("p32_done_pos", c, 0);
      end
    end
    chk("p32_n_vld", n_vld, 10);
    chk("p32_n_done", n_done, 10);
    chk("p32_peak", peak, 31);

    // Enable dropped at edge 3, back after 2 cycles
    sampler_enable = 1'b0;
    Prescale       = 6'd8;
    RX_IN          = 1'b0;
    repeat (3) step();
    sampler_enable = 1'b1;
    run_window("abort_pre", 8, 3, 1'b0);
    sampler_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("abort_cnt", edge_cnt, 0);
      chk("abort_vld", valid_sampled_bit, 0);
      chk("abort_done", bit_done, 0);
      chk("abort_hold", sampled_bit, 1);
    end
    sampler_enable = 1'b1;
    run_window("abort_re", 8, 8, 1'b0);

    // Reset at edge 5 of an active bit
    sampler_enable = 1'b0;
    RX_IN          = 1'b1;
    repeat (3) step();
    sampler_enable = 1'b1;
    run_window("pre_rst", 8, 13, 1'b1);
    chk("pre_rst_cnt5", edge_cnt, 5);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mrst_cnt", edge_cnt, 0);
    chk("mrst_vld", valid_sampled_bit, 0);
    chk("mrst_done", bit_done, 0);
    chk("mrst_bit", sampled_bit, 0);
    run_window("post_rst", 8, 16, 1'b1);

    // Illegal prescale acts as disabled
    sampler_enable = 1'b0;
    step();
    Prescale       = 6'd4;
    sampler_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      RX_IN = i[0];
      step();
      chk("p4_cnt", edge_cnt, 0);
      chk("p4_vld", valid_sampled_bit, 0);
      chk("p4_done", bit_done, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
